beep_alert_core: RTL and testbench

Audible/visual alert generator for the washer controller. It converts operator events (pause toggle, key press) and the end-of-program event into timed beep bursts. It drives an indicator/buzzer enable (`sign_led`), a tone clock (`clk_n`), a remaining-beep count (`times`) and a program-finished flag (`flag_finish`). It sits between the panel/sequencer logic and the buzzer/LED pins and is fully gated by machine power.

---
 rtl/beep_alert_pkg.sv | 28 ++
 rtl/beep_edge_det.sv | 36 +++
 rtl/beep_alert_core.sv | 210 +++++++++++++++++++++
 tb/tb_beep_alert_core.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/beep_alert_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beep_alert_pkg
// Purpose  : Shared FSM state encoding and default timing constants for the
//            washer beep/alert generator.
// Revision : 1.0 - initial release
// ============================================================================
package beep_alert_pkg;

   // Alert sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_DONE = 2'd3
   } beep_state_e;

   // Default timing (clock cycles) and burst length
   localparam int BEEP_ON_DEF      = 4;
   localparam int BEEP_OFF_DEF     = 4;
   localparam int FINISH_BEEPS_DEF = 3;
   localparam int TONE_HALF_DEF    = 1;

   // Width of the remaining-beep counter
   localparam int TIMES_W = 4;

endpackage : beep_alert_pkg
`default_nettype wire

// File: rtl/beep_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : beep_edge_det
// Purpose  : Registered rising-edge detector with synchronous clear. The
//            rise pulse is one cycle wide and appears one edge after the
//            input is first sampled high.
// Revision : 1.0 - initial release
// ============================================================================
module beep_edge_det
   import beep_alert_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic rise
);

   logic prev_q;
   logic rise_q;

   // History register plus registered rise pulse. While cleared the history
   // still follows the input, so a level already high when power returns is
   // not mistaken for a fresh key press.
   always_ff @(posedge clk) begin
      prev_q <= d;
      if (clr) begin
         rise_q <= 1'b0;
      end else begin
         rise_q <= d & ~prev_q;
      end
   end

   assign rise = rise_q;

endmodule : beep_edge_det
`default_nettype wire

// File: rtl/beep_alert_core.sv
`default_nettype none
// ============================================================================
// Module   : beep_alert_core
// Purpose  : Converts pause/key/end-of-program events into timed beep bursts
//            driving buzzer enable, tone clock, remaining-beep count and a
//            program-finished flag. Fully gated by power_led.
// Options  : BEEP_ALERT_TONE_EN - when defined, clk_n toggles every
//            TONE_HALF cycles during a beep; otherwise clk_n is held at 0.
// Revision : 1.0 - initial release
// ============================================================================
module beep_alert_core
   import beep_alert_pkg::*;
#(
   parameter int BEEP_ON      = BEEP_ON_DEF,
   parameter int BEEP_OFF     = BEEP_OFF_DEF,
   parameter int FINISH_BEEPS = FINISH_BEEPS_DEF,
   parameter int TONE_HALF    = TONE_HALF_DEF
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               power_led,
   input  logic               pause,
   input  logic               button,
   input  logic               finish,
   output logic [TIMES_W-1:0] times,
   output logic               flag_finish,
   output logic               clk_n,
   output logic               sign_led
);

   localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   // Reject parameter sets the timing scheme cannot represent
   if ((BEEP_ON < 1) || (BEEP_OFF < 1) || (TONE_HALF < 1) ||
       (FINISH_BEEPS < 1) || (FINISH_BEEPS > 15)) begin : g_cfg_check
      $error("beep_alert_core: illegal parameter set");
   end

   // Power-off behaves exactly like reset
   logic clr;
   assign clr = rst | ~power_led;

   logic rise_pause;
   logic rise_button;
   logic rise_finish;
   logic rise_key;

   beep_edge_det u_edge_pause (
      .clk  (clk),
      .clr  (clr),
      .d    (pause),
      .rise (rise_pause)
   );

   beep_edge_det u_edge_button (
      .clk  (clk),
      .clr  (clr),
      .d    (button),
      .rise (rise_button)
   );

   beep_edge_det u_edge_finish (
      .clk  (clk),
      .clr  (clr),
      .d    (finish),
      .rise (rise_finish)
   );

   // Pause and button share one request: simultaneous presses give one beep
   assign rise_key = rise_pause | rise_button;

   beep_state_e         state_q, state_d;
   logic [TIMES_W-1:0]  times_q, times_d;
   logic                fin_burst_q, fin_burst_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic                sign_led_q, sign_led_d;
   logic                flag_finish_q, flag_finish_d;
   logic                clk_n_q, clk_n_d;
   logic                start;  // a new ON phase begins on this edge

   // Next-state, phase counter and burst bookkeeping
   always_comb begin
      state_d     = state_q;
      times_d     = times_q;
      fin_burst_d = fin_burst_q;
      phase_d     = phase_q;
      start       = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (rise_finish) begin
               state_d     = ST_ON;
               times_d     = TIMES_W'(FINISH_BEEPS);
               fin_burst_d = 1'b1;
               phase_d     = '0;
               start       = 1'b1;
            end else if (rise_key) begin
               state_d     = ST_ON;
               times_d     = TIMES_W'(1);
               fin_burst_d = 1'b0;
               phase_d     = '0;
               start       = 1'b1;
            end
         end
         ST_ON: begin
            if (rise_finish) begin
               times_d     = TIMES_W'(FINISH_BEEPS);
               fin_burst_d = 1'b1;
               phase_d     = '0;
               start       = 1'b1;
            end else if (phase_q == PH_W'(BEEP_ON - 1)) begin
               state_d = ST_OFF;
               phase_d = '0;
               if (times_q != '0) begin
                  times_d = times_q - TIMES_W'(1);
               end
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         ST_OFF: begin
            if (rise_finish) begin
               state_d     = ST_ON;
               times_d     = TIMES_W'(FINISH_BEEPS);
               fin_burst_d = 1'b1;
               phase_d     = '0;
               start       = 1'b1;
            end else if (phase_q == PH_W'(BEEP_OFF - 1)) begin
               phase_d = '0;
               if (times_q != '0) begin
                  state_d = ST_ON;
                  start   = 1'b1;
               end else if (fin_burst_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      sign_led_d    = (state_d == ST_ON);
      flag_finish_d = (state_d == ST_DONE);
   end

`ifdef BEEP_ALERT_TONE_EN
   localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

   logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;

   // Tone divider: restarts low on every ON entry, silent outside ON
   always_comb begin
      tone_cnt_d = '0;
      clk_n_d    = 1'b0;
      if ((state_d == ST_ON) && !start) begin
         if (tone_cnt_q == TONE_W'(TONE_HALF - 1)) begin
            tone_cnt_d = '0;
            clk_n_d    = ~clk_n_q;
         end else begin
            tone_cnt_d = tone_cnt_q + TONE_W'(1);
            clk_n_d    = clk_n_q;
         end
      end
   end

   // Tone divider count register
   always_ff @(posedge clk) begin
      if (clr) begin
         tone_cnt_q <= '0;
      end else begin
         tone_cnt_q <= tone_cnt_d;
      end
   end
`else
   // Tone output disabled: buzzer enable alone drives the sounder
   assign clk_n_d = 1'b0;
`endif

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q       <= ST_IDLE;
         times_q       <= '0;
         fin_burst_q   <= 1'b0;
         phase_q       <= '0;
         sign_led_q    <= 1'b0;
         flag_finish_q <= 1'b0;
         clk_n_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         times_q       <= times_d;
         fin_burst_q   <= fin_burst_d;
         phase_q       <= phase_d;
         sign_led_q    <= sign_led_d;
         flag_finish_q <= flag_finish_d;
         clk_n_q       <= clk_n_d;
      end
   end

   assign times       = times_q;
   assign flag_finish = flag_finish_q;
   assign clk_n       = clk_n_q;
   assign sign_led    = sign_led_q;

endmodule : beep_alert_core
`default_nettype wire

// File: tb/tb_beep_alert_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_beep_alert_core
// Purpose  : Self-checking bench for beep_alert_core. A burst-level model
//            (burst length and elapsed cycles) predicts every output each
//            cycle; directed sequences pin the model with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beep_alert_core;

   localparam int P_ON  = 4;
   localparam int P_OFF = 4;
   localparam int P_FB  = 3;
   localparam int P_TH  = 1;
   localparam int PER   = P_ON + P_OFF;

   logic       clk = 1'b0;
   logic       rst, power_led, pause, button, finish;
   logic [3:0] times;
   logic       flag_finish, clk_n, sign_led;

   always #5 clk = ~clk;

   beep_alert_core #(
      .BEEP_ON      (P_ON),
      .BEEP_OFF     (P_OFF),
      .FINISH_BEEPS (P_FB),
      .TONE_HALF    (P_TH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .power_led   (power_led),
      .pause       (pause),
      .button      (button),
      .finish      (finish),
      .times       (times),
      .flag_finish (flag_finish),
      .clk_n       (clk_n),
      .sign_led    (sign_led)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- burst-level reference model ----------------
   bit m_active, m_done, m_fin;
   int m_n, m_t;
   bit m_pend_fin, m_pend_key;
   bit m_prev_p, m_prev_b, m_prev_f;

   initial begin
      m_active = 0; m_done = 0; m_fin = 0; m_n = 0; m_t = 0;
      m_pend_fin = 0; m_pend_key = 0;
      m_prev_p = 0; m_prev_b = 0; m_prev_f = 0;
   end

   // Model advances on each rising edge using the inputs present at that edge
   always @(posedge clk) begin
      if (rst || !power_led) begin
         m_active = 0; m_done = 0; m_fin = 0; m_t = 0; m_n = 0;
         m_pend_fin = 0; m_pend_key = 0;
      end else begin
         if (m_pend_fin) begin
            m_active = 1; m_done = 0; m_fin = 1; m_n = P_FB; m_t = 0;
         end else if (m_pend_key && !m_active) begin
            m_active = 1; m_done = 0; m_fin = 0; m_n = 1; m_t = 0;
         end else if (m_active) begin
            m_t++;
            if (m_t == m_n * PER) begin
               m_active = 0;
               m_done   = m_fin;
            end
         end
         m_pend_fin = finish && !m_prev_f;
         m_pend_key = (pause && !m_prev_p) || (button && !m_prev_b);
      end
      m_prev_p = pause;
      m_prev_b = button;
      m_prev_f = finish;
   end

   function automatic logic exp_sign();
      return m_active && ((m_t % PER) < P_ON);
   endfunction

   function automatic logic [3:0] exp_times();
      int w;
      if (!m_active) return 4'd0;
      w = m_t % PER;
      return 4'(m_n - (m_t / PER) - ((w >= P_ON) ? 1 : 0));
   endfunction

   function automatic logic exp_flag();
      return m_done && !m_active;
   endfunction

   function automatic logic exp_clkn();
`ifdef BEEP_ALERT_TONE_EN
      if (!exp_sign()) return 1'b0;
      return 1'(((m_t % PER) / P_TH) % 2);
`else
      return 1'b0;
`endif
   endfunction

   // Compare process: every cycle, away from the rising edge
   always @(negedge clk) begin
      if (check_en) begin
         check("model_times", times, exp_times());
         check("model_sign_led", sign_led, exp_sign());
         check("model_flag_finish", flag_finish, exp_flag());
         check("model_clk_n", clk_n, exp_clkn());
      end
   end

   // Overall time bound
   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      int rate_k, rate_f, rate_p;
      rst = 1; power_led = 0; pause = 0; button = 1; finish = 0;
      repeat (3) @(negedge clk);
      check_en = 1;
      power_led = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      // Key held through power-up must not beep
      repeat (10) begin
         @(negedge clk);
         check("pwrup_quiet", {sign_led, times, flag_finish, clk_n}, 0);
      end
      button = 0;
      @(negedge clk);

      // Single beep from a 1-cycle pause pulse
      pause = 1;
      @(negedge clk);
      pause = 0;
      check("beep_latency", sign_led, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("beep_sign", sign_led, (i < 4) ? 1 : 0);
         check("beep_times", times, (i < 4) ? 1 : 0);
      end
      check("beep_no_flag", flag_finish, 0);

      // Finish burst
      finish = 1;
      @(negedge clk);
      finish = 0;
      for (int i = 0; i < 28; i++) begin
         @(negedge clk);
         if (i == 0)  check("fin_times_start", times, 3);
         if (i == 4)  check("fin_times_after1", times, 2);
         if (i == 8)  check("fin_sign_beep2", sign_led, 1);
         if (i == 16) check("fin_times_beep3", times, 1);
         if (i == 20) check("fin_times_zero", times, 0);
         if (i == 23) check("fin_flag_early", flag_finish, 0);
         if (i == 24) check("fin_flag_set", flag_finish, 1);
         if (i == 27) check("fin_flag_held", {flag_finish, sign_led}, 2'b10);
      end

      // Key in DONE: single beep clears the flag
      pause = 1;
      @(negedge clk);
      pause = 0;
      @(negedge clk);
      check("done_key_flag", flag_finish, 0);
      check("done_key_sign", sign_led, 1);
      check("done_key_times", times, 1);
      // Button during the beep is dropped
      button = 1;
      @(negedge clk);
      button = 0;
      @(negedge clk);
      check("btn_ignored", times, 1);
      // Finish during the beep restarts a full burst
      finish = 1;
      @(negedge clk);
      finish = 0;
      @(negedge clk);
      check("fin_preempt_times", times, 3);
      check("fin_preempt_sign", sign_led, 1);
      repeat (30) @(negedge clk);

      // Power off mid finish burst
      finish = 1;
      @(negedge clk);
      finish = 0;
      repeat (10) @(negedge clk);
      power_led = 0;
      @(negedge clk);
      check("pwroff_clear", {sign_led, times, flag_finish, clk_n}, 0);
      power_led = 1;
      repeat (10) begin
         @(negedge clk);
         check("pwron_idle", {sign_led, times, flag_finish, clk_n}, 0);
      end

      // Randomized segments with varying event densities
      for (int seg = 0; seg < 4; seg++) begin
         rate_k = (seg == 0) ? 20 : (seg == 1) ? 5 : (seg == 2) ? 2 : 50;
         rate_f = (seg == 0) ? 2  : (seg == 1) ? 10 : (seg == 2) ? 1 : 30;
         rate_p = (seg == 3) ? 20 : 3;
         for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            pause     = ($urandom_range(0, 999) < rate_k * 10);
            button    = ($urandom_range(0, 999) < rate_k * 10);
            finish    = ($urandom_range(0, 999) < rate_f * 10);
            power_led = ($urandom_range(0, 999) >= rate_p);
            rst       = ($urandom_range(0, 999) < 2);
         end
      end
      rst = 0; power_led = 1; pause = 0; button = 0; finish = 0;
      repeat (40) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_beep_alert_core
`default_nettype wire
